mem_access_unit: RTL
====================

# mem_access_unit

MEM-stage load/store initiator for the pipelined MIPS CPU. It accepts one load or store per transaction from the pipeline and drives the word-only data memory port (`MemRead`/`MemWrite`/`Addr`/`Wdata`/`Rdata`). It performs byte/halfword extraction with sign or zero extension, and read-modify-write for sub-word stores. It signals busy back to the pipeline so the hazard unit can stall.

## Interface
Parameters:
- `WORD_ADDR`, 1: when 1, `mem_addr` = `req_addr[31:2]` zero-extended (word index); when 0, `mem_addr` = `req_addr`.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  1  pipeline presents a request.
- `req_ready`  out  1  high only in IDLE; accept = `req_valid & req_ready`.
- `req_op`  in  4  MIPS opcode[3:0]: LB 0000, LH 0001, LW 0011, LBU 0100, LHU 0101, SB 1000, SH 1001, SW 1011.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; low byte/half used for SB/SH.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal op; valid with `resp_valid`.
- `MemRead`  out  1  data memory read strobe.
- `MemWrite`  out  1  data memory write strobe.
- `Addr`  out  32  data memory word address.
- `Wdata`  out  32  data memory write word.
- `Rdata`  in  32  data memory read word; valid the cycle after `MemRead` is sampled.

## Operation
- States: IDLE, RD, RD_CAP, WR, RESP.
- All outputs are registered. Reset value of every output is 0, except `req_ready` = 1.
- Byte order is big-endian. Byte offset 0 is `[31:24]`; offset 3 is `[7:0]`. Half offset 0 is `[31:16]`.
- Alignment rules:
  - LW/SW need `addr[1:0]==0`.
  - LH/LHU/SH need `addr[0]==0`.
  - Bytes are always aligned.
- Misaligned or illegal opcode: IDLE→RESP. No memory strobe. `resp_err`=1, `resp_rdata`=0.
- LW/LB/LH/LBU/LHU: IDLE→RD (`MemRead`=1, `Addr` set) → RD_CAP. In RD_CAP, the lane is extracted from `Rdata`, then sign-extended (LB/LH) or zero-extended (LBU/LHU). The result is registered and the FSM goes to RESP.
- SW: IDLE→WR (`MemWrite`=1, `Wdata`=`req_wdata`) → RESP.
- SB/SH: IDLE→RD (`MemRead`) → RD_CAP. In RD_CAP, the target lane of `Rdata` is replaced with the store data. Then WR (`MemWrite`, merged `Wdata`) → RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. `req_ready` returns high in the cycle after RESP.
- `MemRead` and `MemWrite` are never high in the same cycle. Each is high for exactly one cycle per access.
- `Addr` holds its value from RD through WR of the same transaction.
- Request fields are latched at accept. Changes to them during busy are ignored.

## Timing
Cycle 0 is the accept cycle. `resp_valid` is asserted in:
- error: cycle 1
- SW: cycle 2
- loads: cycle 3
- SB/SH: cycle 4

Throughput is one transaction per (latency+1) cycles. There is no pipelining across transactions.

Reset mid-operation:
- `rst_n` low at an edge forces IDLE and zeroes all outputs at that edge.
- A `MemWrite` driven in the cycle before that edge is still committed by the memory.
- A read-modify-write interrupted in RD or RD_CAP issues no write.
- No `resp_valid` is produced for an abandoned transaction.

Back-to-back: a `req_valid` held high across RESP is accepted in the first IDLE cycle.

## Structure
- Shared package `mips_mem_pkg` holds:
  - the op encodings (`OP_LB` … `OP_SW`)
  - the FSM state enum
  - the `is_store`/`is_aligned` helper constants
- Sub-module `mem_lane_align` is purely combinational:
  - inputs: word, byte offset, op, store data
  - outputs: extracted load value and merged store word
- The FSM and registers stay in `mem_access_unit`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles → all outputs 0, `req_ready`=1. After release, no strobes without a request.
- LW `0x00400004`, memory word `0x00100001`=`0x11223344` → `MemRead`=1 with `Addr`=`0x00100001` in cycle 1; `resp_valid` with `resp_rdata`=`0x11223344` in cycle 3.
- LB `0x00400007` on word `0x112233F4` → `resp_rdata`=`0xFFFFFFF4`; LBU at the same address → `0x000000F4`; LH `0x00400004` → `0x00001122`.
- SH `0x00400006`, `req_wdata`=`0xAAAABEEF`, old word `0x11223344` → `MemRead` in cycle 1; `MemWrite` with `Wdata`=`0x1122BEEF` in cycle 3; `resp_valid` in cycle 4. Memory reads back `0x1122BEEF`.
- LW `0x00400002` and op `0111` → `resp_err`=1 in cycle 1, `resp_rdata`=0, `MemRead`/`MemWrite` never asserted.
- SB started, then `rst_n`=0 at the RD_CAP edge → no `MemWrite`, no `resp_valid`, `req_ready`=1 after reset. Memory word unchanged.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: opcodes, FSM states
// and small decode helpers.
package mips_mem_pkg;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_CAP,
    S_WR,
    S_RESP
  } mau_state_e;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic is_aligned(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         return (off == 2'b00);
      OP_LH, OP_LHU, OP_SH: return (off[0] == 1'b0);
      default:              return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling: extracts/extends load data and merges sub-word
// store data into the word read from memory. Purely combinational.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select, extension and store merge
  always_comb begin
    w_byte   = 8'h00;
    w_half   = i_off[1] ? i_word[15:0] : i_word[31:16];
    o_load   = i_word;
    o_merged = i_wdata;
    case (i_off)
      2'd0:    w_byte = i_word[31:24];
      2'd1:    w_byte = i_word[23:16];
      2'd2:    w_byte = i_word[15:8];
      default: w_byte = i_word[7:0];
    endcase
    case (i_op)
      OP_LB:  o_load = {{24{w_byte[7]}}, w_byte};
      OP_LBU: o_load = {24'h000000, w_byte};
      OP_LH:  o_load = {{16{w_half[15]}}, w_half};
      OP_LHU: o_load = {16'h0000, w_half};
      OP_SB: begin
        o_merged = i_word;
        case (i_off)
          2'd0:    o_merged[31:24] = i_wdata[7:0];
          2'd1:    o_merged[23:16] = i_wdata[7:0];
          2'd2:    o_merged[15:8]  = i_wdata[7:0];
          default: o_merged[7:0]   = i_wdata[7:0];
        endcase
      end
      OP_SH: o_merged = i_off[1] ? {i_word[31:16], i_wdata[15:0]}
                                 : {i_wdata[15:0], i_word[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: one transaction at a time against a
// word-only data memory, with read-modify-write for byte/half stores.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned WORD_ADDR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Addr,
  output logic [31:0] Wdata,
  input  logic [31:0] Rdata
);

  mau_state_e  r_state, w_nxt_state;
  logic [3:0]  r_op;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;

  logic        w_accept;
  logic [31:0] w_req_maddr;
  logic [31:0] w_nxt_rdata, w_nxt_addr, w_nxt_wdata;
  logic        w_nxt_err;
  logic [31:0] w_load, w_merged;

  assign w_req_maddr = (WORD_ADDR != 0) ? {2'b00, req_addr[31:2]} : req_addr;

  mem_lane_align u_align (
    .i_word   (Rdata),
    .i_off    (r_off),
    .i_op     (r_op),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  // Next-state and next-output decode; strobes/valid/ready follow the next state
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_rdata = resp_rdata;
    w_nxt_err   = resp_err;
    w_nxt_addr  = Addr;
    w_nxt_wdata = Wdata;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          w_accept    = 1'b1;
          w_nxt_rdata = '0;
          w_nxt_err   = 1'b0;
          if (!is_legal(req_op) || !is_aligned(req_op, req_addr[1:0])) begin
            w_nxt_err   = 1'b1;
            w_nxt_state = S_RESP;
          end else if (req_op == OP_SW) begin
            w_nxt_addr  = w_req_maddr;
            w_nxt_wdata = req_wdata;
            w_nxt_state = S_WR;
          end else begin
            w_nxt_addr  = w_req_maddr;
            w_nxt_state = S_RD;
          end
        end
      end
      S_RD:     w_nxt_state = S_RD_CAP;
      S_RD_CAP: begin
        if (is_store(r_op)) begin
          w_nxt_wdata = w_merged;
          w_nxt_state = S_WR;
        end else begin
          w_nxt_rdata = w_load;
          w_nxt_state = S_RESP;
        end
      end
      S_WR:     w_nxt_state = S_RESP;
      S_RESP: begin
        w_nxt_rdata = '0;
        w_nxt_err   = 1'b0;
        w_nxt_state = S_IDLE;
      end
      default:  w_nxt_state = S_IDLE;
    endcase
  end

  // State, latched request fields and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_off      <= '0;
      r_wdata    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      Addr       <= '0;
      Wdata      <= '0;
    end else begin
      r_state    <= w_nxt_state;
      if (w_accept) begin
        r_op    <= req_op;
        r_off   <= req_addr[1:0];
        r_wdata <= req_wdata;
      end
      req_ready  <= (w_nxt_state == S_IDLE);
      resp_valid <= (w_nxt_state == S_RESP);
      MemRead    <= (w_nxt_state == S_RD);
      MemWrite   <= (w_nxt_state == S_WR);
      resp_rdata <= w_nxt_rdata;
      resp_err   <= w_nxt_err;
      Addr       <= w_nxt_addr;
      Wdata      <= w_nxt_wdata;
    end
  end

endmodule
